// File: rtl/n101_qspi_icb_bridge_pkg.sv
// Shared peripheral constants and types for the QSPI ICB front-end bridge.
package n101_qspi_icb_bridge_pkg;

  localparam int unsigned N101_ADDR_SIZE = 32;

  localparam logic [31:0] QSPI_BASE_ADDR = 32'h1001_4000;
  localparam int unsigned QSPI_WIN_BITS  = 12;
  localparam logic [31:0] ERR_RDATA      = 32'h0;

  localparam int unsigned OUTS_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ERR  = 1'b1
  } bridge_state_e;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] data;
  } rsp_buf_t;

  function automatic logic full_word(input logic read, input logic [3:0] wmask);
    return read | (wmask == 4'hF);
  endfunction

endpackage

// File: rtl/n101_qspi_icb_bridge_if.sv
// ICB command/response bundle; master drives commands, slave drives responses.
interface n101_qspi_icb_bridge_if
  import n101_qspi_icb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = N101_ADDR_SIZE
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_read;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/n101_qspi_icb_bridge.sv
// ICB front-end for the QSPI core: rejects illegal accesses locally, bounds
// outstanding commands and registers the response path in a one-entry buffer.
module n101_qspi_icb_bridge
  import n101_qspi_icb_bridge_pkg::*;
#(
  parameter int unsigned       ADDR_W    = N101_ADDR_SIZE,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(QSPI_BASE_ADDR),
  parameter int unsigned       WIN_BITS  = QSPI_WIN_BITS,
  parameter int unsigned       MAX_OUTS  = 2
)(
  input  logic                  clk,
  input  logic                  rst_n,
  n101_qspi_icb_bridge_if.slave  s,
  n101_qspi_icb_bridge_if.master m
);

  localparam logic [OUTS_W-1:0] MAX_OUTS_C = OUTS_W'(MAX_OUTS);

  bridge_state_e     state_q, state_d;
  logic [OUTS_W-1:0] outs_q, outs_d;
  rsp_buf_t          rbuf_q, rbuf_d;

  logic hit, aligned, fullw, legal;
  logic room, buf_free, err_ok;
  logic s_cmd_ready_c, m_cmd_valid_c, m_rsp_ready_c;
  logic err_acc, m_cmd_hs, m_rsp_hs, fwd_rsp, s_rsp_hs;

  assign hit     = s.cmd_addr[ADDR_W-1:WIN_BITS] == BASE_ADDR[ADDR_W-1:WIN_BITS];
  assign aligned = s.cmd_addr[1:0] == 2'b00;
  assign fullw   = full_word(s.cmd_read, s.cmd_wmask);
  assign legal   = hit & aligned & fullw;

  assign room     = outs_q < MAX_OUTS_C;
  assign buf_free = ~rbuf_q.vld | s.rsp_ready;
  // Error responses may only enter an otherwise empty pipe to keep order.
  assign err_ok   = (outs_q == '0) & buf_free;

  assign m_rsp_ready_c = buf_free;
  assign m_cmd_hs      = m_cmd_valid_c & m.cmd_ready;
  assign m_rsp_hs      = m.rsp_valid & m_rsp_ready_c;
  assign fwd_rsp       = m_rsp_hs & (outs_q != '0);
  assign s_rsp_hs      = rbuf_q.vld & s.rsp_ready;

  // FSM
  // state   | meaning
  // ST_IDLE | commands forwarded or rejected normally
  // ST_ERR  | error response pending upstream, command path blocked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (err_acc)  state_d = ST_ERR;
      ST_ERR:  if (s_rsp_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_cmd_ready_c = 1'b0;
    m_cmd_valid_c = 1'b0;
    err_acc       = 1'b0;
    if ((state_q == ST_IDLE) && s.cmd_valid) begin
      if (legal) begin
        m_cmd_valid_c = room;
        s_cmd_ready_c = room & m.cmd_ready;
      end else begin
        s_cmd_ready_c = err_ok;
        err_acc       = err_ok;
      end
    end
  end

  // Outstanding counter; stray responses with nothing outstanding are dropped.
  always_comb begin
    outs_d = outs_q;
    case ({m_cmd_hs, fwd_rsp})
      2'b10:   outs_d = outs_q + OUTS_W'(1);
      2'b01:   outs_d = outs_q - OUTS_W'(1);
      default: outs_d = outs_q;
    endcase
  end

  always_comb begin
    rbuf_d = rbuf_q;
    if (s_rsp_hs) begin
      rbuf_d.vld = 1'b0;
    end
    if (fwd_rsp) begin
      rbuf_d = '{vld: 1'b1, err: 1'b0, data: m.rsp_rdata};
    end else if (err_acc) begin
      rbuf_d = '{vld: 1'b1, err: 1'b1, data: ERR_RDATA};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outs_q <= '0;
      rbuf_q <= '0;
    end else begin
      outs_q <= outs_d;
      rbuf_q <= rbuf_d;
    end
  end

  assign s.cmd_ready = s_cmd_ready_c;
  assign s.rsp_valid = rbuf_q.vld;
  assign s.rsp_rdata = rbuf_q.data;
  assign s.rsp_err   = rbuf_q.err;

  assign m.cmd_valid = m_cmd_valid_c;
  assign m.cmd_addr  = s.cmd_addr;
  assign m.cmd_read  = s.cmd_read;
  assign m.cmd_wdata = s.cmd_wdata;
  assign m.cmd_wmask = s.cmd_wmask;
  assign m.rsp_ready = m_rsp_ready_c;

endmodule

// File: tb/tb_n101_qspi_icb_bridge.sv
// Directed bench for n101_qspi_icb_bridge with a transaction-level response model.
module tb_n101_qspi_icb_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  n101_qspi_icb_bridge_if #(.ADDR_W(32)) s_if ();
  n101_qspi_icb_bridge_if #(.ADDR_W(32)) m_if ();

  n101_qspi_icb_bridge #(
    .ADDR_W   (32),
    .BASE_ADDR(32'h1001_4000),
    .WIN_BITS (12),
    .MAX_OUTS (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s    (s_if),
    .m    (m_if)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic bit legal_f(input logic [31:0] a, input logic rd, input logic [3:0] wm);
    return ((a >> 12) == (32'h1001_4000 >> 12)) && ((a % 4) == 0) && (rd || (wm == 4'b1111));
  endfunction

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return (a == 32'h1001_4040) ? 32'hDEAD_BEEF : {16'hC0DE, a[15:0]};
  endfunction

  // Model state: outstanding count and queue of responses owed upstream
  int   mdl_outs = 0;
  bit   mdl_err_pend = 0;
  rsp_t mq[$];
  rsp_t log_q[$];
  int   obs_outs = 0;
  int   max_outs = 0;
  int   fwd_total = 0;

  initial begin : cmp
    bit lg, room, e_mv, e_sr, e_mrr, drain, mrsp, mcmd, eacc;
    logic [31:0] rd_in;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mdl_outs = 0;
        mdl_err_pend = 0;
        mq.delete();
        obs_outs = 0;
        chk("rst_s_rsp_valid", s_if.rsp_valid, 0);
        chk("rst_s_rsp_rdata", s_if.rsp_rdata, 0);
        chk("rst_s_rsp_err",   s_if.rsp_err, 0);
        chk("rst_m_cmd_valid", m_if.cmd_valid, 0);
        chk("rst_m_rsp_ready", m_if.rsp_ready, 1);
        chk("rst_s_cmd_ready", s_if.cmd_ready, 0);
      end else begin
        lg    = legal_f(s_if.cmd_addr, s_if.cmd_read, s_if.cmd_wmask);
        room  = mdl_outs < 2;
        e_mv  = s_if.cmd_valid && lg && room && !mdl_err_pend;
        e_sr  = s_if.cmd_valid && !mdl_err_pend &&
                (lg ? (room && m_if.cmd_ready)
                    : (mdl_outs == 0 && (mq.size() == 0 || s_if.rsp_ready)));
        e_mrr = (mq.size() == 0) || s_if.rsp_ready;
        chk("m_cmd_valid", m_if.cmd_valid, e_mv);
        chk("s_cmd_ready", s_if.cmd_ready, e_sr);
        chk("m_rsp_ready", m_if.rsp_ready, e_mrr);
        chk("s_rsp_valid", s_if.rsp_valid, mq.size() != 0);
        if (e_mv) begin
          chk("m_cmd_addr",  m_if.cmd_addr,  s_if.cmd_addr);
          chk("m_cmd_read",  m_if.cmd_read,  s_if.cmd_read);
          chk("m_cmd_wdata", m_if.cmd_wdata, s_if.cmd_wdata);
        end
        if (mq.size() != 0) begin
          chk("s_rsp_rdata", s_if.rsp_rdata, mq[0].d);
          chk("s_rsp_err",   s_if.rsp_err,   mq[0].e);
        end
        if (s_if.rsp_valid && s_if.rsp_ready)
          log_q.push_back('{d: s_if.rsp_rdata, e: s_if.rsp_err});
        if (m_if.cmd_valid && m_if.cmd_ready) begin
          obs_outs++;
          fwd_total++;
        end
        if (m_if.rsp_valid && m_if.rsp_ready && obs_outs > 0) obs_outs--;
        if (obs_outs > max_outs) max_outs = obs_outs;
        drain = (mq.size() != 0) && s_if.rsp_ready;
        mrsp  = m_if.rsp_valid && e_mrr && (mdl_outs > 0);
        mcmd  = e_mv && m_if.cmd_ready;
        eacc  = s_if.cmd_valid && !lg && e_sr;
        rd_in = m_if.rsp_rdata;
        @(posedge clk);
        if (drain) begin
          if (mq[0].e) mdl_err_pend = 0;
          void'(mq.pop_front());
        end
        if (mrsp) mq.push_back('{d: rd_in, e: 1'b0});
        if (eacc) begin
          mq.push_back('{d: 32'h0, e: 1'b1});
          mdl_err_pend = 1;
        end
        mdl_outs = mdl_outs + int'(mcmd) - int'(mrsp);
      end
    end
  end

  // QSPI-side responder: answers accepted commands in order
  logic        slv_cmd_ready = 1'b1;
  logic        slv_rsp_en = 1'b1;
  logic        stray = 1'b0;
  logic [31:0] stray_data = 32'h0;
  logic [31:0] pend[$];

  initial begin : slave
    m_if.cmd_ready = 1'b0;
    m_if.rsp_valid = 1'b0;
    m_if.rsp_rdata = 32'h0;
    m_if.rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
      end else begin
        if (m_if.rsp_valid && m_if.rsp_ready && !stray && pend.size() > 0)
          void'(pend.pop_front());
        if (m_if.cmd_valid && m_if.cmd_ready)
          pend.push_back(m_if.cmd_read ? slv_data(m_if.cmd_addr) : 32'h0);
      end
      @(posedge clk);
      #2;
      m_if.cmd_ready = slv_cmd_ready;
      if (stray) begin
        m_if.rsp_valid = 1'b1;
        m_if.rsp_rdata = stray_data;
      end else if (slv_rsp_en && pend.size() > 0) begin
        m_if.rsp_valid = 1'b1;
        m_if.rsp_rdata = pend[0];
      end else begin
        m_if.rsp_valid = 1'b0;
        m_if.rsp_rdata = 32'h0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic rd, input logic [3:0] wm);
    bit done = 0;
    s_if.cmd_valid = 1'b1;
    s_if.cmd_addr  = a;
    s_if.cmd_read  = rd;
    s_if.cmd_wdata = a ^ 32'h5555_AAAA;
    s_if.cmd_wmask = wm;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (s_if.cmd_ready) done = 1;
      @(posedge clk);
      #1;
    end
    s_if.cmd_valid = 1'b0;
    chk($sformatf("accept_%h", a), done, 1);
  endtask

  task automatic wait_log(input int n);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (log_q.size() >= n) ok = 1;
      else cyc();
    end
    chk($sformatf("rsp_count_%0d", n), ok, 1);
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] d, input logic e);
    if (idx < log_q.size()) begin
      chk({name, "_rdata"}, log_q[idx].d, d);
      chk({name, "_err"},   log_q[idx].e, e);
    end else begin
      chk({name, "_present"}, log_q.size(), idx + 1);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int fwd_base;

  initial begin : main
    s_if.cmd_valid = 1'b0;
    s_if.cmd_addr  = 32'h0;
    s_if.cmd_read  = 1'b0;
    s_if.cmd_wdata = 32'h0;
    s_if.cmd_wmask = 4'h0;
    s_if.rsp_ready = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // legal read
    log_q.delete();
    send_cmd(32'h1001_4040, 1'b1, 4'h0);
    wait_log(1);
    chk_log("rd_deadbeef", 0, 32'hDEAD_BEEF, 1'b0);

    // misaligned then out-of-window writes
    log_q.delete();
    fwd_base = fwd_total;
    send_cmd(32'h1001_4002, 1'b0, 4'hF);
    send_cmd(32'h1002_0000, 1'b0, 4'hF);
    wait_log(2);
    chk("err_no_forward", fwd_total - fwd_base, 0);
    chk_log("err_misaligned", 0, 32'h0, 1'b1);
    chk_log("err_outwin",     1, 32'h0, 1'b1);

    // partial write behind two outstanding reads
    log_q.delete();
    slv_rsp_en = 1'b0;
    send_cmd(32'h1001_4100, 1'b1, 4'h0);
    send_cmd(32'h1001_4104, 1'b1, 4'h0);
    fork
      send_cmd(32'h1001_4008, 1'b0, 4'h3);
      begin
        repeat (5) cyc();
        slv_rsp_en = 1'b1;
      end
    join
    wait_log(3);
    chk_log("order_rd0", 0, 32'hC0DE_4100, 1'b0);
    chk_log("order_rd1", 1, 32'hC0DE_4104, 1'b0);
    chk_log("order_err", 2, 32'h0, 1'b1);

    // burst of 4 reads against a stalled slave
    log_q.delete();
    repeat (2) cyc();
    max_outs = 0;
    fwd_base = fwd_total;
    slv_cmd_ready = 1'b0;
    slv_rsp_en = 1'b0;
    fork
      for (int i = 0; i < 4; i++) send_cmd(32'h1001_4200 + 32'(4 * i), 1'b1, 4'h0);
      begin
        repeat (3) cyc();
        slv_cmd_ready = 1'b1;
        repeat (4) cyc();
        chk("burst_fwd_before_rsp", fwd_total - fwd_base, 2);
        slv_rsp_en = 1'b1;
      end
    join
    wait_log(4);
    chk("burst_max_outs", max_outs, 2);
    for (int i = 0; i < 4; i++)
      chk_log($sformatf("burst_%0d", i), i, {16'hC0DE, 16'h4200 + 16'(4 * i)}, 1'b0);

    // upstream ready toggling 1010...
    log_q.delete();
    fork
      for (int i = 0; i < 6; i++) send_cmd(32'h1001_4300 + 32'(4 * i), 1'b1, 4'h0);
      for (int i = 0; i < 80 && log_q.size() < 6; i++) begin
        s_if.rsp_ready = (i % 2 == 0);
        cyc();
      end
    join
    s_if.rsp_ready = 1'b1;
    wait_log(6);
    repeat (4) cyc();
    chk("toggle_no_dup", log_q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk_log($sformatf("toggle_%0d", i), i, {16'hC0DE, 16'h4300 + 16'(4 * i)}, 1'b0);

    // reset with one read outstanding, then a stray response
    log_q.delete();
    slv_rsp_en = 1'b0;
    send_cmd(32'h1001_4400, 1'b1, 4'h0);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("midrst_s_rsp_valid", s_if.rsp_valid, 0);
    chk("midrst_m_cmd_valid", m_if.cmd_valid, 0);
    chk("midrst_m_rsp_ready", m_if.rsp_ready, 1);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    stray_data = 32'h5A5A_5A5A;
    stray = 1'b1;
    cyc();
    stray = 1'b0;
    repeat (3) cyc();
    chk("stray_discarded", log_q.size(), 0);
    slv_rsp_en = 1'b1;
    send_cmd(32'h1001_4080, 1'b1, 4'h0);
    wait_log(1);
    chk_log("post_rst_rd", 0, 32'hC0DE_4080, 1'b0);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
